// File: rtl/pc_sequencer_if.sv
// Bundles the fetch, execute and status signals of the program-control sequencer.
// The slave modport is used by the sequencer itself; the master modport is used by its environment.
interface pc_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic        exec_start;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        link_en;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        link_valid;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] instr_count;

    modport slave (
        input  imem_ack,
        input  exec_done,
        input  branch_taken,
        input  branch_target,
        input  link_en,
        input  halt_req,
        output imem_req,
        output exec_start,
        output pc,
        output link_addr,
        output link_valid,
        output halted,
        output err_code,
        output instr_count
    );

    modport master (
        output imem_ack,
        output exec_done,
        output branch_taken,
        output branch_target,
        output link_en,
        output halt_req,
        input  imem_req,
        input  exec_start,
        input  pc,
        input  link_addr,
        input  link_valid,
        input  halted,
        input  err_code,
        input  instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: FETCH -> ISSUE -> WAIT loop, minimum 3 cycles per instruction.
// Waits indefinitely on imem_ack; WAIT is bounded by TIMEOUT; HALT/ERROR are left only via rst.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 64
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("pc_sequencer: TIMEOUT must be in 1..1023");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("pc_sequencer: RESET_PC must be word aligned");
    end

    typedef enum logic [2:0] {
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [31:0]      r_link_addr;
    logic [31:0]      w_link_addr_nxt;
    logic             r_link_vld;
    logic             w_link_vld_nxt;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_code_nxt;
    logic [31:0]      r_instr_cnt;
    logic [31:0]      w_instr_cnt_nxt;

    logic [31:0]      w_pc_plus4;
    logic [CNT_W-1:0] w_wait_cnt_inc;
    logic             w_misaligned;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);
    assign w_misaligned   = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_wait_cnt  <= '0;
            r_link_addr <= '0;
            r_link_vld  <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_instr_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_link_addr <= w_link_addr_nxt;
            r_link_vld  <= w_link_vld_nxt;
            r_err_code  <= w_err_code_nxt;
            r_instr_cnt <= w_instr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_link_addr_nxt = r_link_addr;
        w_link_vld_nxt  = 1'b0;
        w_err_code_nxt  = r_err_code;
        w_instr_cnt_nxt = r_instr_cnt;

        case (r_state)
            S_FETCH: begin
                // Halt wins over a returning fetch so the stop lands on an instruction boundary.
                if (bus.halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (bus.imem_ack) begin
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_WAIT;
            end

            S_WAIT: begin
                w_wait_cnt_nxt = w_wait_cnt_inc;
                if (bus.exec_done) begin
                    if (w_misaligned) begin
                        w_err_code_nxt = ERR_MISALIGN;
                        w_state_nxt    = S_ERROR;
                    end else begin
                        w_pc_nxt        = bus.branch_taken ? bus.branch_target : w_pc_plus4;
                        w_instr_cnt_nxt = r_instr_cnt + 32'd1;
                        if (bus.link_en) begin
                            w_link_addr_nxt = w_pc_plus4;
                            w_link_vld_nxt  = 1'b1;
                        end
                        w_state_nxt = bus.halt_req ? S_HALT : S_FETCH;
                    end
                end else if (w_wait_cnt_inc == TIMEOUT_CNT) begin
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = S_ERROR;
                end
            end

            S_HALT:  w_state_nxt = S_HALT;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_ERROR;
        endcase
    end

    // State-decoded strobes are masked during reset so nothing leaks out while rst is high.
    assign bus.imem_req    = !rst && (r_state == S_FETCH);
    assign bus.exec_start  = !rst && (r_state == S_ISSUE);
    assign bus.halted      = !rst && ((r_state == S_HALT) || (r_state == S_ERROR));
    assign bus.pc          = r_pc;
    assign bus.link_addr   = r_link_addr;
    assign bus.link_valid  = r_link_vld;
    assign bus.err_code    = r_err_code;
    assign bus.instr_count = r_instr_cnt;

    a_pc_aligned: assert property (@(posedge clk) disable iff (rst) r_pc[1:0] == 2'b00);
    a_err_legal:  assert property (@(posedge clk) disable iff (rst) r_err_code != 2'd3);
    a_link_pulse: assert property (@(posedge clk) disable iff (rst) r_link_vld |=> !r_link_vld);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          link_hi_cycles = 0;
    logic [31:0] exp_cnt;
    logic [31:0] exp_start_q[$];
    logic [31:0] exp_link_q[$];
    int          start_cyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every exec_start / link_valid strobe is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.exec_start === 1'b1) begin
                start_cyc.push_back(cyc);
                if (exp_start_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_exec_start: got pc %h expected no issue", bus.pc);
                end else begin
                    chk("exec_start_pc", bus.pc, exp_start_q.pop_front());
                end
            end
            if (bus.link_valid === 1'b1) begin
                link_hi_cycles++;
                if (exp_link_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_link_valid: got link_addr %h expected no link", bus.link_addr);
                end else begin
                    chk("link_addr", bus.link_addr, exp_link_q.pop_front());
                end
            end
        end
    end

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.exec_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL wait_exec_start: got no exec_start in 200 cycles expected one");
        end
    endtask

    // One instruction: exec_done presented after dly extra WAIT cycles; returns just after the retire edge.
    task automatic run_instr(input logic [31:0] pc_exp, input logic tk, input logic [31:0] tgt,
                             input logic lnk, input logic hlt, input int dly);
        bit ok;
        bit retires;
        retires = !(tk && (tgt[1:0] != 2'b00));
        exp_start_q.push_back(pc_exp);
        if (lnk && retires) exp_link_q.push_back(pc_exp + 32'd4);
        wait_start(ok);
        if (!ok) return;
        @(posedge clk); #1;
        repeat (dly) begin @(posedge clk); #1; end
        bus.exec_done = 1'b1; bus.branch_taken = tk; bus.branch_target = tgt;
        bus.link_en = lnk; bus.halt_req = hlt;
        @(posedge clk); #1;
        bus.exec_done = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0; bus.link_en = 1'b0;
        if (retires) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b1; bus.exec_done = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = '0; bus.link_en = 1'b0; bus.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_instr_count", bus.instr_count, 32'd0);
        chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);
        chk("rst_link_addr", bus.link_addr, 32'd0);
        chk("rst_link_valid", {31'd0, bus.link_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_cnt = 32'd0;
        do_reset();
        @(negedge clk);
        chk("fetch_after_rst", {31'd0, bus.imem_req}, 32'd1);

        // Sequential run, 3 back-to-back instructions.
        run_instr(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        run_instr(32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        run_instr(32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("seq_pc", bus.pc, 32'hC);
        chk("seq_instr_count", bus.instr_count, 32'd3);
        chk("seq_spacing_1", 32'(start_cyc[1] - start_cyc[0]), 32'd3);
        chk("seq_spacing_2", 32'(start_cyc[2] - start_cyc[1]), 32'd3);

        // Taken branch with link at 0x10.
        run_instr(32'hC, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        run_instr(32'h10, 1'b1, 32'h40, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("branch_pc", bus.pc, 32'h40);
        chk("branch_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("branch_link_addr", bus.link_addr, 32'h14);
        run_instr(32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 2);
        run_instr(32'h44, 1'b1, 32'h20, 1'b0, 1'b0, 1);

        // Misaligned target at 0x20.
        run_instr(32'h20, 1'b1, 32'h42, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("mis_halted", {31'd0, bus.halted}, 32'd1);
        chk("mis_err_code", {30'd0, bus.err_code}, 32'd1);
        chk("mis_pc", bus.pc, 32'h20);
        chk("mis_instr_count", bus.instr_count, exp_cnt);
        chk("mis_imem_req", {31'd0, bus.imem_req}, 32'd0);
        bus.exec_done = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
        bus.link_en = 1'b1; bus.halt_req = 1'b1;
        repeat (5) @(negedge clk);
        bus.exec_done = 1'b0; bus.branch_taken = 1'b0; bus.link_en = 1'b0; bus.halt_req = 1'b0;
        @(negedge clk);
        chk("mis_hold_pc", bus.pc, 32'h20);
        chk("mis_hold_err", {30'd0, bus.err_code}, 32'd1);
        chk("mis_hold_count", bus.instr_count, 32'd7);
        chk("mis_hold_link", bus.link_addr, 32'h44);

        // Timeout: exec_done never comes.
        do_reset();
        exp_start_q.push_back(32'h0);
        begin
            bit ok;
            wait_start(ok);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (bus.halted !== 1'b1 && n < 200);
        chk("timeout_cycles", 32'(n), 32'd65);
        chk("timeout_err_code", {30'd0, bus.err_code}, 32'd2);
        chk("timeout_pc", bus.pc, 32'h0);
        chk("timeout_count", bus.instr_count, 32'd0);

        // exec_done on the 64th WAIT cycle still retires.
        do_reset();
        run_instr(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 63);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("late_done_err", {30'd0, bus.err_code}, 32'd0);
        chk("late_done_halted", {31'd0, bus.halted}, 32'd0);
        chk("late_done_pc", bus.pc, 32'h4);
        chk("late_done_count", bus.instr_count, 32'd1);

        // Halt together with exec_done at 0x8.
        do_reset();
        run_instr(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        run_instr(32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        run_instr(32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("halt_done_pc", bus.pc, 32'hC);
        chk("halt_done_halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_done_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("halt_done_count", bus.instr_count, 32'd3);
        bus.halt_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("halt_sticky", {31'd0, bus.halted}, 32'd1);

        // Halt in FETCH concurrent with imem_ack.
        do_reset();
        run_instr(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        bus.halt_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt_fetch_halted", {31'd0, bus.halted}, 32'd1);
        chk("halt_fetch_pc", bus.pc, 32'h4);
        chk("halt_fetch_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("halt_fetch_count", bus.instr_count, 32'd1);
        bus.halt_req = 1'b0;

        // Reset mid-WAIT with exec_done/link_en present on the same edge.
        do_reset();
        run_instr(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        exp_start_q.push_back(32'h4);
        begin
            bit ok;
            wait_start(ok);
        end
        @(posedge clk); #1;
        bus.exec_done = 1'b1; bus.link_en = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        bus.exec_done = 1'b0; bus.link_en = 1'b0;
        @(negedge clk);
        chk("midrst_pc", bus.pc, 32'h0);
        chk("midrst_count", bus.instr_count, 32'd0);
        chk("midrst_link_valid", {31'd0, bus.link_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 32'd0;

        // PC wrap at 0xFFFF_FFFC.
        run_instr(32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 0);
        run_instr(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_count", bus.instr_count, exp_cnt);
        chk("wrap_link_addr", bus.link_addr, 32'h0);
        repeat (3) @(negedge clk);
        chk("fetch_stall_req", {31'd0, bus.imem_req}, 32'd1);

        chk("start_q_drained", 32'(exp_start_q.size()), 32'd0);
        chk("link_q_drained", 32'(exp_link_q.size()), 32'd0);
        chk("link_valid_cycles", 32'(link_hi_cycles), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
